// File: rtl/line_buffer.sv
// Line buffer: keeps KERNEL_HEIGHT-1 previous image rows and, for every
// incoming raster pixel, presents the vertical column of KERNEL_HEIGHT
// pixels (oldest row in slot 0, incoming pixel in the top slot) one cycle
// later. Output is only flagged valid once enough rows of the current frame
// have been seen to fill the whole column.
module line_buffer #(
    parameter int IMAGE_WIDTH   = 16,
    parameter int IMAGE_NB      = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int ROW_MAX       = 256
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [$clog2(ROW_MAX+1)-1:0]              cfg_row_len,
    input  logic                                      cfg_valid,
    input  logic [IMAGE_WIDTH*IMAGE_NB-1:0]           str_pixel,
    input  logic                                      str_valid,
    output logic [IMAGE_WIDTH*IMAGE_NB*KERNEL_HEIGHT-1:0] image,
    output logic                                      image_valid
);

    localparam int WORD_WIDTH = IMAGE_WIDTH * IMAGE_NB;
    localparam int LEN_W      = $clog2(ROW_MAX + 1);
    localparam int COL_W      = (ROW_MAX > 1) ? $clog2(ROW_MAX) : 1;
    localparam int FILL_W     = (KERNEL_HEIGHT > 2) ? $clog2(KERNEL_HEIGHT) : 1;

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(KERNEL_HEIGHT - 1);
    localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(ROW_MAX);

    logic [LEN_W-1:0]                        row_len_reg;
    logic [COL_W-1:0]                        col_reg;
    logic [FILL_W-1:0]                       fill_reg;
    logic [WORD_WIDTH*KERNEL_HEIGHT-1:0]     image_reg;
    logic                                    image_valid_reg;

    logic [COL_W-1:0]                        col_next;
    logic [FILL_W-1:0]                       fill_next;
    logic                                    cfg_ok;
    logic                                    accept;
    logic                                    col_last;

    // Current column: stored rows at col below, the live pixel on top.
    logic [WORD_WIDTH*KERNEL_HEIGHT-1:0]     column;

    assign column[(KERNEL_HEIGHT-1)*WORD_WIDTH +: WORD_WIDTH] = str_pixel;

    // Decode the cycle's action and the next column/row-count position.
    always_comb begin
        cfg_ok    = 1'b0;
        accept    = 1'b0;
        col_last  = 1'b0;
        col_next  = col_reg;
        fill_next = fill_reg;

        // Out-of-range lengths are treated as if cfg_valid was never raised.
        cfg_ok   = cfg_valid && (cfg_row_len != '0) && (cfg_row_len <= LEN_MAX);
        // A legal configuration wins over a pixel arriving in the same cycle.
        accept   = str_valid && !cfg_ok;
        col_last = (LEN_W'(col_reg) == (row_len_reg - LEN_W'(1)));

        if (col_last) begin
            col_next = '0;
            if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end
        end else begin
            col_next = col_reg + COL_W'(1);
        end
    end

    // One memory per stored row; row gi takes over row gi+1's word at col,
    // and the newest stored row takes the incoming pixel.
    generate
        for (genvar gi = 0; gi < KERNEL_HEIGHT - 1; gi++) begin : g_row
            logic [WORD_WIDTH-1:0] mem [ROW_MAX];

            assign column[gi*WORD_WIDTH +: WORD_WIDTH] = mem[col_reg];

            // Shift this row's word at the current column on every accepted pixel.
            always_ff @(posedge clk) begin
                if (!rst && accept) begin
                    mem[col_reg] <= column[(gi+1)*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    endgenerate

    // Frame control and registered column output.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_len_reg     <= LEN_MAX;
            col_reg         <= '0;
            fill_reg        <= '0;
            image_reg       <= '0;
            image_valid_reg <= 1'b0;
        end else if (cfg_ok) begin
            row_len_reg     <= cfg_row_len;
            col_reg         <= '0;
            fill_reg        <= '0;
            image_valid_reg <= 1'b0;
        end else if (accept) begin
            col_reg         <= col_next;
            fill_reg        <= fill_next;
            image_reg       <= column;
            image_valid_reg <= (fill_reg == FILL_FULL);
        end else begin
            image_valid_reg <= 1'b0;
        end
    end

    assign image       = image_reg;
    assign image_valid = image_valid_reg;

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer (KERNEL_HEIGHT=3, IMAGE_NB=3, ROW_MAX=256).
// Pixel p(r,c) = 10r+c in every channel. The driver pushes each expected
// output column (with the cycle it must appear in) onto a queue; a monitor
// on the falling edge pops and compares whenever image_valid is high.
module tb_line_buffer;

    localparam int IW = 16;
    localparam int NB = 3;
    localparam int KH = 3;
    localparam int RM = 256;
    localparam int WW = IW * NB;
    localparam int LW = $clog2(RM + 1);

    typedef struct {
        logic [WW*KH-1:0] img;
        int               cyc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic [LW-1:0]      cfg_row_len;
    logic               cfg_valid;
    logic [WW-1:0]      str_pixel;
    logic               str_valid;
    logic [WW*KH-1:0]   image;
    logic               image_valid;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    line_buffer #(
        .IMAGE_WIDTH  (IW),
        .IMAGE_NB     (NB),
        .KERNEL_HEIGHT(KH),
        .ROW_MAX      (RM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_row_len(cfg_row_len),
        .cfg_valid  (cfg_valid),
        .str_pixel  (str_pixel),
        .str_valid  (str_valid),
        .image      (image),
        .image_valid(image_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [WW-1:0] pw(input int v);
        return {NB{16'(v)}};
    endfunction

    function automatic logic [WW*KH-1:0] mk(input int s0, input int s1, input int s2);
        return {pw(s2), pw(s1), pw(s0)};
    endfunction

    // Monitor: every valid column must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && image_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid cyc=%0d image=%h expected no output", cyc, image);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (image !== e.img || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL column cyc=%0d image=%h required cyc=%0d image=%h",
                             cyc, image, e.cyc, e.img);
                end else begin
                    $display("ok column cyc=%0d image=%h", cyc, image);
                end
            end
        end
    end

    task automatic check_now(input string name, input logic [WW*KH-1:0] img_req, input logic v_req);
        checks++;
        if (image !== img_req || image_valid !== v_req) begin
            errors++;
            $display("FAIL %s image=%h valid=%b required image=%h valid=%b",
                     name, image, image_valid, img_req, v_req);
        end else begin
            $display("ok %s valid=%b", name, image_valid);
        end
    endtask

    task automatic check_invalid(input string name);
        checks++;
        if (image_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s valid=%b required valid=0", name, image_valid);
        end else begin
            $display("ok %s valid=0", name);
        end
    endtask

    // Drive one pixel; all tasks start and end 1 time unit after a rising edge.
    task automatic send(input int v, input bit expv, input int s0, input int s1, input int s2);
        exp_t e;
        str_pixel = pw(v);
        str_valid = 1'b1;
        if (expv) begin
            e.img = mk(s0, s1, s2);
            e.cyc = cyc + 1;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        str_valid = 1'b0;
    endtask

    task automatic idle();
        str_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cfg(input int len);
        cfg_row_len = LW'(len);
        cfg_valid   = 1'b1;
        @(posedge clk); #1;
        cfg_valid   = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        cfg_row_len = '0;
        cfg_valid   = 1'b0;
        str_pixel   = '0;
        str_valid   = 1'b0;

        // Reset held for 6 cycles while pixels are offered.
        for (int i = 0; i < 6; i++) begin
            str_pixel = pw(100 + i);
            str_valid = 1'b1;
            @(posedge clk); #1;
            check_now("reset_hold", '0, 1'b0);
        end
        str_valid = 1'b0;
        rst = 1'b0;
        idle();
        check_now("post_reset", '0, 1'b0);

        // Row length 4, rows 0..2 back to back; only row 2 produces output.
        cfg(4);
        check_invalid("cfg_len4");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                send(10*r + c, r == 2, c, 10 + c, 20 + c);

        // Row 3 with a 5-cycle gap after column 1: output held, not valid.
        send(30, 1'b1, 10, 20, 30);
        send(31, 1'b1, 11, 21, 31);
        for (int i = 0; i < 5; i++) begin
            idle();
            check_now("gap_hold", mk(11, 21, 31), 1'b0);
        end
        send(32, 1'b1, 12, 22, 32);
        send(33, 1'b1, 13, 23, 33);

        // Row 4: two pixels, then cfg collides with a pixel which is dropped.
        send(40, 1'b1, 20, 30, 40);
        send(41, 1'b1, 21, 31, 41);
        str_pixel   = pw(42);
        str_valid   = 1'b1;
        cfg_row_len = LW'(4);
        cfg_valid   = 1'b1;
        @(posedge clk); #1;
        str_valid   = 1'b0;
        cfg_valid   = 1'b0;
        check_invalid("cfg_drop");
        // New frame: 8 silent pixels, 9th yields (0,10,20).
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 4; c++)
                send(10*r + c, r == 2, c, 10 + c, 20 + c);

        // Zero length is ignored: frame continues with length 4, rows stay full.
        cfg(0);
        check_invalid("cfg_zero");
        for (int c = 0; c < 4; c++)
            send(30 + c, 1'b1, 10 + c, 20 + c, 30 + c);

        // Full-width rows: first valid column on pixel 512.
        cfg(RM);
        check_invalid("cfg_max");
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < RM; c++)
                send(10*r + c, r == 2, c, 10 + c, 20 + c);

        repeat (4) idle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_outputs pending=%0d required pending=0", exp_q.size());
        end else begin
            $display("ok scoreboard drained");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
